// File: rtl/sale_lcd_pkg.sv
// Shared definitions for the sale-terminal LCD writers: line geometry,
// HD44780 command bytes and the line-writer state type.
package sale_lcd_pkg;

  localparam int LINE_CHARS = 11;
  localparam int CHAR_W     = 7;
  localparam int LINE_W     = LINE_CHARS * CHAR_W;
  localparam int TIMER_W    = 16;

  localparam logic [7:0] LCD_CMD_DDRAM_ROW0 = 8'h80;
  localparam logic [7:0] LCD_CMD_DDRAM_ROW1 = 8'hC0;
  localparam logic [7:0] ASCII_SPACE        = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    WAIT
  } lcd_state_t;

  // Character n of a packed line (char 0 sits in the top bits).
  function automatic logic [CHAR_W-1:0] line_char(input logic [LINE_W-1:0] line,
                                                  input logic [3:0]        n);
    logic [LINE_W-1:0] w_sh;
    w_sh = line << (CHAR_W * n);
    return w_sh[LINE_W-1 -: CHAR_W];
  endfunction

endpackage

// File: rtl/lcd_char_map.sv
// 7-bit ASCII to LCD byte. Null becomes a space so an empty field
// overwrites whatever was previously shown in that column.
module lcd_char_map
  import sale_lcd_pkg::*;
(
  input  logic [CHAR_W-1:0] i_char,
  output logic [7:0]        o_byte
);

  // Null maps to space, everything else passes through zero-extended.
  always_comb begin
    o_byte = {1'b0, i_char};
    if (i_char == '0) begin
      o_byte = ASCII_SPACE;
    end
  end

endmodule

// File: rtl/lcd_line_writer.sv
// Writes one latched 11-character line to an HD44780 LCD in 8-bit mode:
// a DDRAM address command followed by 11 data bytes, each framed by a
// setup / E-high / execution-wait sequence.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after a line
// SETUP | RS/DB driven, E low, before the rising edge of E
// PULSE | E held high
// WAIT  | E low, LCD executing the transfer
module lcd_line_writer
  import sale_lcd_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int E_CYC     = 12,
  parameter int WAIT_CYC  = 2000,
  parameter int START_COL = 0
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              row,
  input  logic [LINE_W-1:0] dat,
  output logic              busy,
  output logic              done,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_e,
  output logic [7:0]        lcd_db
);

  if (SETUP_CYC < 1 || SETUP_CYC > 65535) begin : g_bad_setup
    $error("lcd_line_writer: SETUP_CYC must be 1..65535");
  end
  if (E_CYC < 1 || E_CYC > 65535) begin : g_bad_e
    $error("lcd_line_writer: E_CYC must be 1..65535");
  end
  if (WAIT_CYC < 1 || WAIT_CYC > 65535) begin : g_bad_wait
    $error("lcd_line_writer: WAIT_CYC must be 1..65535");
  end
  if (START_COL < 0 || START_COL > 5) begin : g_bad_col
    $error("lcd_line_writer: START_COL must be 0..5");
  end

  // Timer loads are count-1 so each state lasts exactly its cycle count.
  localparam logic [TIMER_W-1:0] L_SETUP  = 16'(SETUP_CYC - 1);
  localparam logic [TIMER_W-1:0] L_PULSE  = 16'(E_CYC - 1);
  localparam logic [TIMER_W-1:0] L_WAIT   = 16'(WAIT_CYC - 1);
  localparam logic [7:0]         L_COL    = 8'(START_COL);
  localparam logic [3:0]         LAST_IDX = 4'(LINE_CHARS);

  lcd_state_t         r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [3:0]         r_idx;
  logic [LINE_W-1:0]  r_line;
  logic               r_busy;
  logic               r_done;
  logic               r_rs;
  logic               r_e;
  logic [7:0]         r_db;

  lcd_state_t         w_state_nxt;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic [3:0]         w_idx_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_rs_nxt;
  logic               w_e_nxt;
  logic [7:0]         w_db_nxt;
  logic               w_line_ld;
  logic [7:0]         w_cmd;
  logic [CHAR_W-1:0]  w_char;
  logic [7:0]         w_char_byte;

  // The byte loaded on the next SETUP entry is char r_idx, because that
  // entry moves to transfer r_idx+1.
  assign w_cmd  = (row ? LCD_CMD_DDRAM_ROW1 : LCD_CMD_DDRAM_ROW0) | L_COL;
  assign w_char = line_char(r_line, r_idx);

  lcd_char_map u_char_map (
    .i_char (w_char),
    .o_byte (w_char_byte)
  );

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_idx_nxt   = r_idx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_rs_nxt    = r_rs;
    w_e_nxt     = r_e;
    w_db_nxt    = r_db;
    w_line_ld   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SETUP;
          w_timer_nxt = L_SETUP;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_rs_nxt    = 1'b0;
          w_e_nxt     = 1'b0;
          w_db_nxt    = w_cmd;
          w_line_ld   = 1'b1;
        end
      end
      SETUP: begin
        if (r_timer == '0) begin
          w_state_nxt = PULSE;
          w_timer_nxt = L_PULSE;
          w_e_nxt     = 1'b1;
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      PULSE: begin
        if (r_timer == '0) begin
          w_state_nxt = WAIT;
          w_timer_nxt = L_WAIT;
          w_e_nxt     = 1'b0;
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      WAIT: begin
        if (r_timer == '0) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = SETUP;
            w_timer_nxt = L_SETUP;
            w_idx_nxt   = r_idx + 4'd1;
            w_rs_nxt    = 1'b1;
            w_db_nxt    = w_char_byte;
          end
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, timer, index, shadow line and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_line  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rs    <= 1'b0;
      r_e     <= 1'b0;
      r_db    <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_rs    <= w_rs_nxt;
      r_e     <= w_e_nxt;
      r_db    <= w_db_nxt;
      if (w_line_ld) begin
        r_line <= dat;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign lcd_rs = r_rs;
  assign lcd_rw = 1'b0;
  assign lcd_e  = r_e;
  assign lcd_db = r_db;

endmodule

// File: tb/tb_lcd_line_writer.sv
// Bench for lcd_line_writer: two instances (START_COL 0 and 2) share all
// inputs; a bus monitor captures every E pulse and checks E timing.
module tb_lcd_line_writer;

  localparam int S  = 1;
  localparam int EC = 2;
  localparam int W  = 3;
  localparam int LINE_CYC = 12 * (S + EC + W);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        row = 1'b0;
  logic [76:0] dat = '0;

  logic       busy [2];
  logic       done [2];
  logic       lcd_rs [2];
  logic       lcd_rw [2];
  logic       lcd_e [2];
  logic [7:0] lcd_db [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lcd_line_writer #(.SETUP_CYC(S), .E_CYC(EC), .WAIT_CYC(W), .START_COL(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .row(row), .dat(dat),
    .busy(busy[0]), .done(done[0]), .lcd_rs(lcd_rs[0]), .lcd_rw(lcd_rw[0]),
    .lcd_e(lcd_e[0]), .lcd_db(lcd_db[0]));

  lcd_line_writer #(.SETUP_CYC(S), .E_CYC(EC), .WAIT_CYC(W), .START_COL(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .row(row), .dat(dat),
    .busy(busy[1]), .done(done[1]), .lcd_rs(lcd_rs[1]), .lcd_rw(lcd_rw[1]),
    .lcd_e(lcd_e[1]), .lcd_db(lcd_db[1]));

  function automatic int col_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  // Expected {rs, db} of transfer n for a line.
  function automatic logic [8:0] exp_xfer(input int col, input logic r,
                                          input logic [76:0] d, input int n);
    logic [6:0] c;
    if (n == 0) return {1'b0, (r ? 8'hC0 : 8'h80) + 8'(col)};
    c = 7'((d >> (7 * (11 - n))) & 77'h7f);
    return (c == 7'h00) ? 9'h120 : {2'b10, c};
  endfunction

  function automatic logic [76:0] rand_line();
    logic [76:0] d;
    logic [6:0]  c;
    d = '0;
    for (int k = 0; k < 11; k++) begin
      c = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom_range(32, 126));
      d = {d[69:0], c};
    end
    return d;
  endfunction

  // ---------------- bus monitor ----------------
  logic [8:0] cap [2][64];
  int         ncap [2];
  int         ndone [2];
  logic       prev_e [2];
  logic [8:0] prev_bus [2];
  int         high_cnt [2];
  int         low_cnt [2];
  bit         first [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      ncap[i] = 0; ndone[i] = 0; prev_e[i] = 1'b0; prev_bus[i] = '0;
      high_cnt[i] = 0; low_cnt[i] = 0; first[i] = 1'b1;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        first[i] = 1'b1; low_cnt[i] = 0; high_cnt[i] = 0; prev_e[i] = 1'b0;
      end else begin
        if (lcd_e[i] && !prev_e[i]) begin
          checks++;
          if (low_cnt[i] < (first[i] ? S : S + W)) begin
            errors++;
            $display("FAIL e_gap dut%0d: low for %0d cycles, need >= %0d", i, low_cnt[i],
                     first[i] ? S : S + W);
          end
          checks++;
          if (lcd_rw[i] !== 1'b0) begin
            errors++;
            $display("FAIL rw_low dut%0d: rw=%b, need 0", i, lcd_rw[i]);
          end
          if (ncap[i] < 64) begin
            cap[i][ncap[i]] = {lcd_rs[i], lcd_db[i]};
            ncap[i]++;
          end
          first[i] = 1'b0;
          high_cnt[i] = 1;
        end else if (lcd_e[i]) begin
          high_cnt[i]++;
          checks++;
          if ({lcd_rs[i], lcd_db[i]} !== prev_bus[i]) begin
            errors++;
            $display("FAIL bus_stable dut%0d: rs/db=%h while E high, was %h", i,
                     {lcd_rs[i], lcd_db[i]}, prev_bus[i]);
          end
        end else if (prev_e[i]) begin
          checks++;
          if (high_cnt[i] != EC) begin
            errors++;
            $display("FAIL e_width dut%0d: E high %0d cycles, need %0d", i, high_cnt[i], EC);
          end
          low_cnt[i] = 1;
        end else begin
          low_cnt[i]++;
        end
        prev_e[i] = lcd_e[i];
      end
      prev_bus[i] = {lcd_rs[i], lcd_db[i]};
      if (done[i] === 1'b1) ndone[i]++;
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int m_nbusy [2];
  bit m_done_fall [2];
  bit m_timeout;

  // Issues one start and returns in the cycle both instances drop busy.
  task automatic run_line(input logic r, input logic [76:0] d);
    bit fell [2];
    row = r; dat = d;
    ncap[0] = 0; ncap[1] = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    fell = '{1'b0, 1'b0};
    m_nbusy = '{0, 0};
    m_done_fall = '{1'b0, 1'b0};
    m_timeout = 1'b1;
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!fell[i]) begin
          if (busy[i] === 1'b1) m_nbusy[i]++;
          else begin fell[i] = 1'b1; m_done_fall[i] = done[i]; end
        end
      end
      if (fell[0] && fell[1]) begin m_timeout = 1'b0; break; end
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; row = 1'b0; dat = '0;
    repeat (3) tick();
    rst = 1'b0;
    ncap[0] = 0; ncap[1] = 0;
    repeat (20) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (busy[i] !== 1'b0 || done[i] !== 1'b0 || lcd_e[i] !== 1'b0 || lcd_rs[i] !== 1'b0 ||
            lcd_rw[i] !== 1'b0 || lcd_db[i] !== 8'h00) begin
          errors++;
          $display("FAIL idle_outputs dut%0d: busy=%b done=%b e=%b rs=%b rw=%b db=%h, need all 0",
                   i, busy[i], done[i], lcd_e[i], lcd_rs[i], lcd_rw[i], lcd_db[i]);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ncap[i] != 0) begin
        errors++;
        $display("FAIL idle_no_e dut%0d: %0d E pulses, need 0", i, ncap[i]);
      end
    end
  endtask

  task automatic test_line_content();
    logic [76:0] d;
    logic        r;
    int          nd [2];
    for (int t = 0; t < 6; t++) begin
      if (t == 0) begin
        r = 1'b0;
        d = {7'h54, 7'h4F, 7'h54, 7'h3A, 7'h33, 7'h31, 7'h32, 7'h2E, 7'h33, 7'h34, 7'h24};
      end else if (t == 1) begin
        r = 1'b1;
        d = '0;
        for (int k = 0; k < 11; k++)
          d = {d[69:0], (k >= 1 && k <= 4) ? 7'h00 : 7'($urandom_range(33, 126))};
      end else begin
        r = 1'($urandom_range(0, 1));
        d = rand_line();
      end
      nd[0] = ndone[0]; nd[1] = ndone[1];
      run_line(r, d);
      checks++;
      if (m_timeout) begin
        errors++;
        $display("FAIL line%0d_timeout: busy still high after 500 cycles, need %0d", t, LINE_CYC);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (m_nbusy[i] != LINE_CYC) begin
          errors++;
          $display("FAIL line%0d_busy_len dut%0d: %0d cycles, need %0d", t, i, m_nbusy[i], LINE_CYC);
        end
        checks++;
        if (m_done_fall[i] !== 1'b1) begin
          errors++;
          $display("FAIL line%0d_done_at_end dut%0d: done=%b, need 1", t, i, m_done_fall[i]);
        end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (done[i] !== 1'b0 || ndone[i] - nd[i] != 1) begin
          errors++;
          $display("FAIL line%0d_done_once dut%0d: done=%b pulses=%0d, need 0 and 1", t, i,
                   done[i], ndone[i] - nd[i]);
        end
        checks++;
        if (ncap[i] != 12) begin
          errors++;
          $display("FAIL line%0d_npulses dut%0d: %0d, need 12", t, i, ncap[i]);
        end
        for (int n = 0; n < 12; n++) begin
          checks++;
          if (cap[i][n] !== exp_xfer(col_of(i), r, d, n)) begin
            errors++;
            $display("FAIL line%0d_xfer%0d dut%0d: rs/db=%h, need %h", t, n, i, cap[i][n],
                     exp_xfer(col_of(i), r, d, n));
          end
        end
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [76:0] d;
    logic        r;
    int          nb;
    bit          to;
    d = rand_line(); r = 1'($urandom_range(0, 1));
    row = r; dat = d; ncap[0] = 0; ncap[1] = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    nb = 0; to = 1'b1;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (busy[0] !== 1'b1) begin to = 1'b0; break; end
      nb++;
      start = (nb == 5 || nb == 40);
      if (start) begin dat = rand_line(); row = ~r; end
      tick();
    end
    start = 1'b0;
    checks++;
    if (to || nb != LINE_CYC || done[0] !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy_len: busy %0d cycles done=%b, need %0d and 1", nb, done[0], LINE_CYC);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ncap[i] != 12 || busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL ignore_npulses dut%0d: %0d pulses busy=%b, need 12 and 0", i, ncap[i], busy[i]);
      end
      for (int n = 0; n < 12; n++) begin
        checks++;
        if (cap[i][n] !== exp_xfer(col_of(i), r, d, n)) begin
          errors++;
          $display("FAIL ignore_xfer%0d dut%0d: rs/db=%h, need %h", n, i, cap[i][n],
                   exp_xfer(col_of(i), r, d, n));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [76:0] d1, d2;
    bit          to;
    int          nb;
    d1 = rand_line(); d2 = rand_line();
    row = 1'b0; dat = d1; ncap[0] = 0; ncap[1] = 0;
    start = 1'b1;
    tick();
    dat = d2; row = 1'b1;
    nb = 0; to = 1'b1;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (busy[0] !== 1'b1) begin to = 1'b0; break; end
      nb++;
      tick();
    end
    checks++;
    if (to || nb != LINE_CYC || done[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_end: busy %0d cycles done=%b, need %0d and 1", nb, done[0], LINE_CYC);
    end
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busy[i] !== 1'b1 || done[i] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_restart dut%0d: busy=%b done=%b, need 1 and 0", i, busy[i], done[i]);
      end
    end
    to = 1'b1;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (busy[0] !== 1'b1) begin to = 1'b0; break; end
      tick();
    end
    tick();
    checks++;
    if (to) begin
      errors++;
      $display("FAIL b2b_second_timeout: busy still high, need low after %0d cycles", LINE_CYC);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ncap[i] != 24) begin
        errors++;
        $display("FAIL b2b_npulses dut%0d: %0d, need 24", i, ncap[i]);
      end
      for (int n = 0; n < 24; n++) begin
        checks++;
        if (cap[i][n] !== ((n < 12) ? exp_xfer(col_of(i), 1'b0, d1, n)
                                    : exp_xfer(col_of(i), 1'b1, d2, n - 12))) begin
          errors++;
          $display("FAIL b2b_xfer%0d dut%0d: rs/db=%h, need %h", n, i, cap[i][n],
                   (n < 12) ? exp_xfer(col_of(i), 1'b0, d1, n) : exp_xfer(col_of(i), 1'b1, d2, n - 12));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [76:0] d;
    logic        r;
    int          nd [2];
    bit          to;
    d = rand_line(); r = 1'($urandom_range(0, 1));
    row = r; dat = d; ncap[0] = 0; ncap[1] = 0;
    nd[0] = ndone[0]; nd[1] = ndone[1];
    start = 1'b1;
    tick();
    start = 1'b0;
    to = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (ncap[0] >= 3 && lcd_e[0] === 1'b1) begin to = 1'b0; break; end
      tick();
    end
    checks++;
    if (to) begin
      errors++;
      $display("FAIL rstmid_no_pulse: third E pulse not seen, need one within 300 cycles");
    end
    rst = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (lcd_e[i] !== 1'b0 || busy[i] !== 1'b0 || done[i] !== 1'b0 || lcd_db[i] !== 8'h00) begin
        errors++;
        $display("FAIL rstmid_outputs dut%0d: e=%b busy=%b done=%b db=%h, need 0 0 0 00",
                 i, lcd_e[i], busy[i], done[i], lcd_db[i]);
      end
    end
    tick();
    rst = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ndone[i] != nd[i]) begin
        errors++;
        $display("FAIL rstmid_no_done dut%0d: %0d done pulses, need 0", i, ndone[i] - nd[i]);
      end
    end
    d = rand_line();
    run_line(r, d);
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (m_timeout || m_nbusy[i] != LINE_CYC || ncap[i] != 12) begin
        errors++;
        $display("FAIL rstmid_replay dut%0d: busy %0d pulses %0d, need %0d and 12",
                 i, m_nbusy[i], ncap[i], LINE_CYC);
      end
      for (int n = 0; n < 12; n++) begin
        checks++;
        if (cap[i][n] !== exp_xfer(col_of(i), r, d, n)) begin
          errors++;
          $display("FAIL rstmid_xfer%0d dut%0d: rs/db=%h, need %h", n, i, cap[i][n],
                   exp_xfer(col_of(i), r, d, n));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_content();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, need completion before 2 ms");
    $fatal(1, "watchdog");
  end

endmodule
